// File: rtl/inst_fetch_pkg.sv
// Shared constants, entry type and sizing helper for the RV32I instruction fetch stage.
package inst_fetch_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, inst} pairs; the head reads as zero when empty.
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = cnt_w(DEPTH)
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  fetch_entry_t  wdata,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge CLK) begin
        if (!RSTN || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTN && !clear && push) mem[wr_ptr] <= wdata;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/inst_fetch.sv
// RV32I fetch stage: credit-limited in-order word fetch, buffered for the decoder,
// with flush-time discard of every response still in flight.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RSTN,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_vld,
    input  logic        dec_freeze,
    input  logic        nop_insert,
    input  logic        csr_hazard,
    input  logic        alu_flush,
    input  logic [31:0] alu_redirect_pc
);
    localparam int CW = cnt_w(DEPTH);

    logic [31:0]   pc, ret_pc;
    logic [CW-1:0] fifo_cnt, inflight, inflight_nxt, discard;
    logic [CW:0]   credits_used;
    logic          issue, resp, push, take;
    fetch_entry_t  wentry, head;

    // Buffered plus outstanding words never exceed DEPTH, so a push never hits a full FIFO.
    assign credits_used = {1'b0, fifo_cnt} + {1'b0, inflight};
    assign imem_req     = ~alu_flush & (credits_used < (CW+1)'(DEPTH));
    assign imem_addr    = pc;
    assign issue        = imem_req & imem_gnt;
    // Responses with nothing outstanding (stragglers from before a reset) are ignored.
    assign resp         = imem_rvalid & (inflight != '0);
    assign push         = resp & (discard == '0) & ~alu_flush;
    assign take         = inst_vld & ~dec_freeze & ~nop_insert & ~csr_hazard & ~alu_flush;
    assign inflight_nxt = inflight + CW'(issue) - CW'(resp);

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            pc       <= RESET_PC;
            ret_pc   <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (alu_flush) begin
                pc      <= alu_redirect_pc;
                ret_pc  <= alu_redirect_pc;
                discard <= inflight_nxt;
            end else begin
                if (issue) pc <= pc + 32'd4;
                if (push)  ret_pc <= ret_pc + 32'd4;
                if (resp && discard != '0) discard <= discard - 1'b1;
            end
        end
    end

    assign wentry.pc   = ret_pc;
    assign wentry.inst = imem_rdata;

    fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .push  (push),
        .pop   (take),
        .clear (alu_flush),
        .wdata (wentry),
        .head  (head),
        .count (fifo_cnt)
    );

    assign inst     = head.inst;
    assign inst_pc  = head.pc;
    assign inst_vld = (fifo_cnt != '0);
endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: random memory/decoder/flush traffic against an
// architectural model (sequential PC stream per segment, word credit bound).
module tb_inst_fetch;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        CLK = 1'b0, RSTN = 1'b0;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0, inst_vld;
    logic [31:0] imem_addr, imem_rdata = '0, inst, inst_pc, alu_redirect_pc = '0;
    logic        dec_freeze = 1'b0, nop_insert = 1'b0, csr_hazard = 1'b0, alu_flush = 1'b0;

    inst_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(inst), .inst_pc(inst_pc), .inst_vld(inst_vld),
        .dec_freeze(dec_freeze), .nop_insert(nop_insert), .csr_hazard(csr_hazard),
        .alu_flush(alu_flush), .alu_redirect_pc(alu_redirect_pc)
    );

    always #5 CLK = ~CLK;

    // kind: 0 live, 1 stale after flush, 2 straggler after reset, 3 spurious
    typedef struct { logic [31:0] addr; int rdy; int kind; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;

    pend_t       pend[$];
    exp_t        sb[$];
    int          cyc = 0, n_cmp = 0, n_bad = 0, live = 0, cur_kind = 0, n_take = 0;
    logic [31:0] fetch_exp = RST_PC;
    bit          prev_rst = 1'b0, prev_flush = 1'b0;
    int          lat_max = 1, gnt_pct = 100, stall_pct = 0, flush_pct = 0, spur_pct = 0;
    bit          force_freeze = 1'b0, fl_force = 1'b0;
    logic [31:0] fl_tgt = '0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock: present memory response, grant, decoder stalls and flush for this cycle.
    task automatic step(input bit rst_n);
        bit zombies;
        @(posedge CLK); #1;
        cyc++;
        RSTN = rst_n;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        cur_kind    = 0;
        if (pend.size() > 0 && pend[0].rdy <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memfn(pend[0].addr);
            cur_kind    = pend[0].kind;
            void'(pend.pop_front());
        end else if (pend.size() == 0 && $urandom_range(0, 99) < spur_pct) begin
            imem_rvalid = 1'b1;
            cur_kind    = 3;
        end
        zombies = 1'b0;
        foreach (pend[i]) if (pend[i].kind == 2) zombies = 1'b1;
        imem_gnt   = rst_n && !zombies && ($urandom_range(0, 99) < gnt_pct);
        dec_freeze = force_freeze || ($urandom_range(0, 99) < stall_pct);
        nop_insert = ($urandom_range(0, 99) < stall_pct / 2);
        csr_hazard = ($urandom_range(0, 99) < stall_pct / 2);
        alu_flush  = fl_force || ($urandom_range(0, 99) < flush_pct);
        if (fl_force) alu_redirect_pc = fl_tgt;
        else if ($urandom_range(0, 3) == 0) alu_redirect_pc = 32'hFFFF_FFF8;
        else alu_redirect_pc = $urandom_range(0, 1023) << 2;
    endtask

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge CLK) begin
        int stale_out;
        bit tk;
        if (!RSTN) begin
            foreach (pend[i]) pend[i].kind = 2;
            sb.delete();
            live       = 0;
            fetch_exp  = RST_PC;
            prev_rst   = 1'b1;
            prev_flush = 1'b0;
        end else begin
            if (prev_rst || prev_flush) begin
                check(prev_rst ? "post_reset_vld" : "post_flush_vld", inst_vld, 1'b0);
            end
            if (!inst_vld) begin
                check("empty_inst", inst, 32'h0);
                check("empty_pc", inst_pc, 32'h0);
            end
            stale_out = 0;
            foreach (pend[i]) if (pend[i].kind == 1) stale_out++;
            if (imem_rvalid && cur_kind == 1) stale_out++;
            check("imem_req", imem_req, (!alu_flush && (stale_out + live < DEPTH)));

            tk = inst_vld && !dec_freeze && !nop_insert && !csr_hazard && !alu_flush;
            if (tk) begin
                if (sb.size() == 0) begin
                    check("unexpected_inst_pc", inst_pc, 32'hDEAD_BEEF);
                end else begin
                    check("inst_pc", inst_pc, sb[0].pc);
                    check("inst", inst, sb[0].word);
                    void'(sb.pop_front());
                    live--;
                    n_take++;
                end
            end
            if (imem_req && imem_gnt) begin
                check("imem_addr", imem_addr, fetch_exp);
                pend.push_back('{addr: imem_addr, rdy: cyc + int'($urandom_range(1, lat_max)), kind: 0});
                sb.push_back('{pc: fetch_exp, word: memfn(fetch_exp)});
                fetch_exp = fetch_exp + 32'd4;
                live++;
            end
            if (alu_flush) begin
                foreach (pend[i]) if (pend[i].kind == 0) pend[i].kind = 1;
                sb.delete();
                live      = 0;
                fetch_exp = alu_redirect_pc;
            end
            prev_flush = alu_flush;
            prev_rst   = 1'b0;
        end
    end

    initial begin
        repeat (3) step(1'b0);
        check("reset_vld", inst_vld, 1'b0);
        check("reset_inst", inst, 32'h0);
        check("reset_pc", inst_pc, 32'h0);
        check("reset_addr", imem_addr, RST_PC);

        // Ideal memory, decoder always consuming.
        repeat (20) step(1'b1);

        // Decoder frozen: buffer fills, requests stop, head holds.
        force_freeze = 1'b1;
        repeat (5) step(1'b1);
        check("freeze_req", imem_req, 1'b0);
        check("freeze_vld", inst_vld, 1'b1);
        check("freeze_head", inst_pc, (sb.size() > 0) ? sb[0].pc : 32'hFFFF_FFFF);
        force_freeze = 1'b0;
        repeat (10) step(1'b1);

        // Redirect to 0x100 with slow memory so responses are in flight.
        lat_max = 3;
        repeat (4) step(1'b1);
        fl_force = 1'b1; fl_tgt = 32'h0000_0100;
        step(1'b1);
        fl_force = 1'b0;
        repeat (20) step(1'b1);

        // Grant withheld: address must hold.
        gnt_pct = 0;
        repeat (3) step(1'b1);
        gnt_pct = 100;
        repeat (10) step(1'b1);

        // Randomized traffic with mid-stream resets.
        for (int r = 0; r < 8; r++) begin
            lat_max   = int'($urandom_range(1, 4));
            gnt_pct   = int'($urandom_range(40, 100));
            stall_pct = int'($urandom_range(0, 40));
            flush_pct = int'($urandom_range(2, 12));
            spur_pct  = int'($urandom_range(0, 20));
            repeat (400) step(1'b1);
            repeat (2) step(1'b0);
        end
        flush_pct = 0; stall_pct = 0;
        repeat (30) step(1'b1);

        check("progress", (n_take >= 300), 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
